// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Key codes are {row, col}, so the accepted code equals 4*row + col.
package keypad_pkg;

   localparam int unsigned NUM_ROWS = 4;
   localparam int unsigned NUM_COLS = 4;
   localparam int unsigned ROW_W    = $clog2(NUM_ROWS);
   localparam int unsigned COL_W    = $clog2(NUM_COLS);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

   typedef logic [3:0] key_code_t;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } kp_cand_t;

   // Row pattern seen when only the given row is pulled low
   function automatic logic [NUM_ROWS-1:0] row_pattern(input logic [ROW_W-1:0] row);
      return ~(NUM_ROWS'(1) << row);
   endfunction

   function automatic logic single_low(input logic [NUM_ROWS-1:0] rows);
      return $countones(~rows) == 1;
   endfunction

   function automatic logic [ROW_W-1:0] low_row_index(input logic [NUM_ROWS-1:0] rows);
      logic [ROW_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < int'(NUM_ROWS); i++) begin
         if (!rows[i]) idx = ROW_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
   parameter int unsigned      WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad one column at a time and reports a debounced key.
// A key is reported once per press; no second key is accepted until all rows are released.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 50000,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_ROWS-1:0] row_n,
   output logic [NUM_COLS-1:0] col_n,
   output key_code_t           key,
   output logic                ready,
   output logic                key_strobe
);

   localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

   kp_state_t           state, state_nxt;
   logic [NUM_ROWS-1:0] rs;
   logic [SLOT_W-1:0]   slot_cnt, slot_nxt;
   logic [DEB_W-1:0]    deb_cnt, deb_nxt;
   logic [COL_W-1:0]    col_idx, col_nxt;
   kp_cand_t            cand, cand_nxt;
   key_code_t           key_nxt;
   logic                ready_nxt;
   logic                strobe_nxt;

   logic slot_done;
   logic deb_done;
   logic one_low;
   logic cand_match;
   logic all_up;

   sync_2ff #(
      .WIDTH     (NUM_ROWS),
      .RESET_VAL ('1)
   ) u_row_sync (
      .clk   (clk),
      .reset (reset),
      .d     (row_n),
      .q     (rs)
   );

   assign slot_done  = (slot_cnt == SLOT_LAST);
   assign deb_done   = (deb_cnt == DEB_LAST);
   assign one_low    = single_low(rs);
   assign cand_match = (rs == row_pattern(cand.row));
   assign all_up     = (rs == '1);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= SCAN;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         SCAN: begin
            if (slot_done && one_low) state_nxt = DEBOUNCE;
         end
         DEBOUNCE: begin
            if (!cand_match)   state_nxt = SCAN;
            else if (deb_done) state_nxt = HELD;
         end
         HELD: begin
            if (!cand_match) state_nxt = RELEASE;
         end
         RELEASE: begin
            if (all_up && deb_done) state_nxt = SCAN;
         end
         default: state_nxt = SCAN;
      endcase
   end

   // Counter, candidate and output next values; the column only moves in SCAN or on abort/release
   always_comb begin
      slot_nxt   = slot_cnt;
      deb_nxt    = deb_cnt;
      col_nxt    = col_idx;
      cand_nxt   = cand;
      key_nxt    = key;
      ready_nxt  = ready;
      strobe_nxt = 1'b0;
      case (state)
         SCAN: begin
            if (slot_done) begin
               slot_nxt = '0;
               if (one_low) begin
                  cand_nxt.row = low_row_index(rs);
                  cand_nxt.col = col_idx;
                  deb_nxt      = '0;
               end else begin
                  col_nxt = col_idx + COL_W'(1);
               end
            end else begin
               slot_nxt = slot_cnt + SLOT_W'(1);
            end
         end
         DEBOUNCE: begin
            if (!cand_match) begin
               deb_nxt  = '0;
               slot_nxt = '0;
               col_nxt  = col_idx + COL_W'(1);
            end else if (deb_done) begin
               deb_nxt    = '0;
               key_nxt    = key_code_t'(cand);
               ready_nxt  = 1'b1;
               strobe_nxt = 1'b1;
            end else begin
               deb_nxt = deb_cnt + DEB_W'(1);
            end
         end
         HELD: begin
            ready_nxt = 1'b1;
            if (!cand_match) deb_nxt = '0;
         end
         RELEASE: begin
            if (!all_up) begin
               deb_nxt = '0;
            end else if (deb_done) begin
               deb_nxt   = '0;
               ready_nxt = 1'b0;
               slot_nxt  = '0;
               col_nxt   = col_idx + COL_W'(1);
            end else begin
               deb_nxt = deb_cnt + DEB_W'(1);
            end
         end
         default: begin
            slot_nxt = '0;
            deb_nxt  = '0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt   <= '0;
         deb_cnt    <= '0;
         col_idx    <= '0;
         cand       <= '0;
         key        <= '0;
         ready      <= 1'b0;
         key_strobe <= 1'b0;
         col_n      <= 4'b1110;
      end else begin
         slot_cnt   <= slot_nxt;
         deb_cnt    <= deb_nxt;
         col_idx    <= col_nxt;
         cand       <= cand_nxt;
         key        <= key_nxt;
         ready      <= ready_nxt;
         key_strobe <= strobe_nxt;
         col_n      <= ~(NUM_COLS'(1) << col_nxt);
      end
   end

endmodule
